udp_tx_frame_arbiter: RTL and testbench
=======================================

// Module: udp_tx_frame_arbiter
// PURPOSE
//  Shares the single byte-wide AXI-Stream TX path to the Ethernet MAC between two frame sources:
//   - port 0: UDP echo/reply generator
//   - port 1: auxiliary report generator
//  Frame-atomic round-robin arbitration; a frame is never interleaved. Registered output stage.
//  Frames longer than MAX_FRAME_LEN are truncated and the excess is discarded. Frame/truncation counters for debug.
// PARAMETERS
//  DATA_WIDTH     8     stream data width (bits)
//  MAX_FRAME_LEN  1514  max bytes forwarded per frame (FCS excluded); must be >=2 and < 2**16
//  CNT_WIDTH      16    width of per-port frame counters
// PORTS
//  clk             in   1           system clock; all logic on rising edge
//  rst             in   1           synchronous, active-high reset
//  s0_axis_tdata   in   DATA_WIDTH  port 0 data
//  s0_axis_tvalid  in   1           port 0 valid
//  s0_axis_tlast   in   1           port 0 end of frame
//  s0_axis_tready  out  1           port 0 ready
//  s1_axis_tdata   in   DATA_WIDTH  port 1 data
//  s1_axis_tvalid  in   1           port 1 valid
//  s1_axis_tlast   in   1           port 1 end of frame
//  s1_axis_tready  out  1           port 1 ready
//  m_axis_tdata    out  DATA_WIDTH  to MAC, registered
//  m_axis_tvalid   out  1           registered
//  m_axis_tlast    out  1           registered; forced high on truncation
//  m_axis_tready   in   1           MAC ready
//  m_src           out  1           source port of current output byte, registered
//  frames_0        out  CNT_WIDTH   frames completed from port 0 (wraps)
//  frames_1        out  CNT_WIDTH   frames completed from port 1 (wraps)
//  trunc_count     out  8           truncated frames, saturates at 255
// BEHAVIOUR
//  Reset:
//   - all outputs 0; state=IDLE; byte_cnt=0; last_grant=1, so port 0 wins the first contest.
//  Output register:
//   - can_load = ~m_axis_tvalid | m_axis_tready.
//   - Accepted input byte appears on m_axis_* the next cycle (latency 1). No bubbles under continuous flow.
//  Readies:
//   - sN_axis_tready = can_load & (N==grant) & state!=IDLE; or in IDLE, the arbitration winner.
//   - Exception in DRAIN: granted tready=1 regardless of can_load.
//   - Non-granted port tready=0 always.
//  FSM:
//   IDLE:
//    - if can_load and any sN_tvalid, pick the winner:
//      - both valid -> the port != last_grant
//      - one valid -> that port
//    - Accept its first byte this same cycle; set grant and last_grant=winner; byte_cnt=1.
//    - First byte tlast=1 -> stay IDLE, count frame; else -> PASS.
//   PASS:
//    - forward each accepted byte of grant; byte_cnt++.
//    - Accepted byte with tlast=1 -> increment frames_<grant>; -> IDLE.
//    - Accepted byte is number MAX_FRAME_LEN with tlast=0:
//      - output it with m_axis_tlast=1; count frame; trunc_count++ (saturating); -> DRAIN.
//   DRAIN:
//    - consume granted port bytes, discard (m_axis unaffected); -> IDLE on the accepted byte with tlast=1.
//  Boundaries:
//   - Frame of exactly MAX_FRAME_LEN bytes ending in tlast -> normal; no truncation.
//   - Request rising on the other port mid-frame waits; no preemption.
//   - A port held valid with a pending frame gets a turn after every frame of the other port.
//   - m_axis_tready low holds m_axis_* stable; input readies drop accordingly. No loss or duplication.
//   - tvalid dropping mid-frame on the granted port -> lock held, output tvalid gaps, no arbitration.
//   - rst mid-frame -> everything returns to reset values next cycle.
//     The partial frame is abandoned; the MAC sees no tlast; the upstream sources are reset too.
// TESTING
//  T1: 42-byte frame on s0, m_ready=1
//      -> 42 bytes out in order, each 1 cycle after input; tlast on byte 42; m_src=0; frames_0=1.
//  T2: s0 and s1 each hold two 10-byte frames valid from the same cycle
//      -> output order s0,s1,s0,s1; no interleave; frames_0=frames_1=2.
//  T3: 60-byte frame on s1 with m_ready toggling 1,0,0,1 pattern
//      -> exact 60-byte sequence out; data stable while m_ready=0.
//  T4: MAX_FRAME_LEN=64, 100-byte frame on s1, then 20-byte frame on s0
//      -> 64 bytes out, tlast on 64th; 36 bytes drained; trunc_count=1; s0 frame follows intact.
//  T5: back-to-back 1-byte frames (tlast=1) on both ports
//      -> strictly alternating output with m_src 0,1,0,1 and tlast on every byte, no idle cycles.
//  T6: rst pulsed at byte 15 of a 40-byte s0 frame; then both ports request
//      -> outputs 0 after reset; port 0 granted first.

Source files
------------

// File: rtl/udp_tx_frame_arbiter_if.sv
// Byte-wide AXI-Stream link used for both the source ports and the MAC-facing port
// of the UDP TX frame arbiter.
interface udp_tx_frame_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/udp_tx_frame_arbiter.sv
// Two-source, frame-atomic round-robin arbiter onto the MAC TX byte stream,
// with a registered output stage, length truncation and debug counters.
module udp_tx_frame_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_FRAME_LEN = 1514,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    udp_tx_frame_arbiter_if.slave  s0_axis,
    udp_tx_frame_arbiter_if.slave  s1_axis,
    udp_tx_frame_arbiter_if.master m_axis,
    output logic                   m_src,
    output logic [CNT_WIDTH-1:0]   frames_0,
    output logic [CNT_WIDTH-1:0]   frames_1,
    output logic [7:0]             trunc_count
);

    typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

    state_t                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic [15:0]             byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic                    src_q, src_d;
    logic [CNT_WIDTH-1:0]    frames0_q, frames0_d;
    logic [CNT_WIDTH-1:0]    frames1_q, frames1_d;
    logic [7:0]              trunc_q, trunc_d;

    logic                    can_load;
    logic                    win;
    logic                    sel;
    logic                    sel_valid;
    logic                    sel_last;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_rdy;
    logic                    accept;
    logic                    load;
    logic                    load_last;
    logic                    count;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Source selection: in IDLE the contest winner, otherwise the locked grant.
    always_comb begin
        can_load  = ~tvalid_q | m_axis.tready;
        win       = (s0_axis.tvalid & s1_axis.tvalid) ? ~last_grant_q : s1_axis.tvalid;
        sel       = (state_q == IDLE) ? win : grant_q;
        sel_valid = sel ? s1_axis.tvalid : s0_axis.tvalid;
        sel_last  = sel ? s1_axis.tlast  : s0_axis.tlast;
        sel_data  = sel ? s1_axis.tdata  : s0_axis.tdata;
        case (state_q)
            IDLE:    sel_rdy = can_load & (s0_axis.tvalid | s1_axis.tvalid);
            PASS:    sel_rdy = can_load;
            default: sel_rdy = 1'b1;
        endcase
        accept = sel_valid & sel_rdy;
    end

    assign s0_axis.tready = sel_rdy & ~sel;
    assign s1_axis.tready = sel_rdy & sel;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        byte_cnt_d   = byte_cnt_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        src_d        = src_q;
        frames0_d    = frames0_q;
        frames1_d    = frames1_q;
        trunc_d      = trunc_q;
        load         = 1'b0;
        load_last    = 1'b0;
        count        = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    byte_cnt_d   = 16'd1;
                    load         = 1'b1;
                    load_last    = sel_last;
                    count        = sel_last;
                    state_d      = sel_last ? IDLE : PASS;
                end
            end
            PASS: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    load       = 1'b1;
                    if (sel_last) begin
                        load_last = 1'b1;
                        count     = 1'b1;
                        state_d   = IDLE;
                    end else if (byte_cnt_q + 16'd1 == MAX_LEN) begin
                        // Length limit hit: close the frame at the MAC and discard the rest.
                        load_last = 1'b1;
                        count     = 1'b1;
                        trunc_d   = sat_inc8(trunc_q);
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (can_load) begin
            tvalid_d = load;
            if (load) begin
                tdata_d = sel_data;
                tlast_d = load_last;
                src_d   = sel;
            end
        end

        if (count) begin
            if (sel) frames1_d = frames1_q + CNT_WIDTH'(1);
            else     frames0_d = frames0_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            byte_cnt_q   <= '0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            src_q        <= 1'b0;
            frames0_q    <= '0;
            frames1_q    <= '0;
            trunc_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            byte_cnt_q   <= byte_cnt_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            src_q        <= src_d;
            frames0_q    <= frames0_d;
            frames1_q    <= frames1_d;
            trunc_q      <= trunc_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_src         = src_q;
    assign frames_0      = frames0_q;
    assign frames_1      = frames1_q;
    assign trunc_count   = trunc_q;

endmodule

// File: tb/tb_udp_tx_frame_arbiter.sv
// Directed bench for udp_tx_frame_arbiter: a per-cycle vector table plus stream sequences.
module tb_udp_tx_frame_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_src;
    logic [15:0] frames_0, frames_1;
    logic [7:0]  trunc_count;

    udp_tx_frame_arbiter_if #(.DATA_WIDTH(8)) s0 ();
    udp_tx_frame_arbiter_if #(.DATA_WIDTH(8)) s1 ();
    udp_tx_frame_arbiter_if #(.DATA_WIDTH(8)) m ();

    udp_tx_frame_arbiter #(.DATA_WIDTH(8), .MAX_FRAME_LEN(64), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .s0_axis(s0), .s1_axis(s1), .m_axis(m),
        .m_src(m_src), .frames_0(frames_0), .frames_1(frames_1), .trunc_count(trunc_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v0; logic [7:0] d0; logic l0;
        logic       v1; logic [7:0] d1; logic l1;
        logic       mr;
        logic       er0; logic er1;
        logic       emv; logic [7:0] ed; logic el; logic es;
    } vec_t;

    typedef struct packed { logic [7:0] d; logic l; logic s; } beat_t;

    int    errors = 0;
    int    checks = 0;
    vec_t  vt[11];
    beat_t src0[$], src1[$], got[$], expq[$];
    int    got_step[$], in0_step[$];
    bit    hs0, hs1, prev_stall, hold0, mr_toggle;
    beat_t prev_beat;
    int    stall_err, stepno;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_tb();
        src0.delete(); src1.delete(); got.delete(); expq.delete();
        got_step.delete(); in0_step.delete();
        hs0 = 0; hs1 = 0; prev_stall = 0; hold0 = 0; mr_toggle = 0;
        stall_err = 0; stepno = 0;
        s0.tvalid = 0; s0.tdata = 0; s0.tlast = 0;
        s1.tvalid = 0; s1.tdata = 0; s1.tlast = 0;
        m.tready = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clear_tb();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic push_frame(input int port, input int len, input logic [7:0] base, input int stride);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = 8'(int'(base) + i * stride);
            b.l = (i == len - 1);
            b.s = port[0];
            if (port == 0) src0.push_back(b); else src1.push_back(b);
        end
    endtask

    // One clock of the source/sink models: drive at negedge, record handshakes before posedge.
    task automatic step();
        @(negedge clk);
        if (hs0) void'(src0.pop_front());
        if (hs1) void'(src1.pop_front());
        s0.tvalid = (src0.size() != 0) && (!hold0 || src1.size() == 0);
        s0.tdata  = (src0.size() != 0) ? src0[0].d : 8'h00;
        s0.tlast  = (src0.size() != 0) ? src0[0].l : 1'b0;
        s1.tvalid = (src1.size() != 0);
        s1.tdata  = (src1.size() != 0) ? src1[0].d : 8'h00;
        s1.tlast  = (src1.size() != 0) ? src1[0].l : 1'b0;
        m.tready  = mr_toggle ? ((stepno % 4 == 0) || (stepno % 4 == 3)) : 1'b1;
        #1;
        hs0 = s0.tvalid & s0.tready;
        hs1 = s1.tvalid & s1.tready;
        if (hs0) in0_step.push_back(stepno);
        if (prev_stall && (!m.tvalid || {m.tdata, m.tlast, m_src} != prev_beat)) stall_err++;
        prev_stall = m.tvalid & ~m.tready;
        prev_beat  = {m.tdata, m.tlast, m_src};
        if (m.tvalid && m.tready) begin
            got.push_back({m.tdata, m.tlast, m_src});
            got_step.push_back(stepno);
        end
        stepno++;
    endtask

    task automatic run(input string name, input int budget);
        int n = 0;
        bit done;
        do begin
            step();
            n++;
            done = (src0.size() == 0) && (src1.size() == 0) && !m.tvalid && !hs0 && !hs1;
        end while (!done && n < budget);
        chk({name, "_complete"}, 32'(done), 32'd1);
    endtask

    task automatic cmp_stream(input string name);
        chk({name, "_len"}, 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk($sformatf("%s_beat%0d", name, i), 32'(got[i]), 32'(expq[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n;
        // v0 d0 l0 | v1 d1 l1 | mr | er0 er1 | emv ed el es
        vt[0]  = '{1'b1, 8'hA1, 1'b1, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB1, 1'b1, 1'b1};
        vt[2]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b1};
        vt[3]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 8'hC0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC0, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 8'hC1, 1'b0, 1'b1, 8'hD0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC1, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hD0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 8'hC2, 1'b1, 1'b1, 8'hD0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC2, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hD0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hD0, 1'b1, 1'b1};
        vt[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        do_reset();
        #1;
        chk("rst_m_tvalid", 32'(m.tvalid), 32'd0);
        chk("rst_m_tdata", 32'(m.tdata), 32'd0);
        chk("rst_m_tlast", 32'(m.tlast), 32'd0);
        chk("rst_m_src", 32'(m_src), 32'd0);
        chk("rst_frames_0", 32'(frames_0), 32'd0);
        chk("rst_frames_1", 32'(frames_1), 32'd0);
        chk("rst_trunc", 32'(trunc_count), 32'd0);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            s0.tvalid = vt[i].v0; s0.tdata = vt[i].d0; s0.tlast = vt[i].l0;
            s1.tvalid = vt[i].v1; s1.tdata = vt[i].d1; s1.tlast = vt[i].l1;
            m.tready  = vt[i].mr;
            #1;
            chk($sformatf("vec%0d_s0_ready", i), 32'(s0.tready), 32'(vt[i].er0));
            chk($sformatf("vec%0d_s1_ready", i), 32'(s1.tready), 32'(vt[i].er1));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_m_tvalid", i), 32'(m.tvalid), 32'(vt[i].emv));
            if (vt[i].emv)
                chk($sformatf("vec%0d_m_beat", i), 32'({m.tdata, m.tlast, m_src}),
                    32'({vt[i].ed, vt[i].el, vt[i].es}));
        end
        chk("vec_frames_0", 32'(frames_0), 32'd3);
        chk("vec_frames_1", 32'(frames_1), 32'd2);
        chk("vec_trunc", 32'(trunc_count), 32'd0);

        // T1: single 42-byte frame, one-cycle latency throughout
        do_reset();
        push_frame(0, 42, 8'h01, 1);
        expq = src0;
        run("t1", 500);
        cmp_stream("t1");
        bad = 0;
        for (int i = 0; i < in0_step.size() && i < got_step.size(); i++)
            if (got_step[i] != in0_step[i] + 1) bad++;
        chk("t1_latency_violations", 32'(bad), 32'd0);
        chk("t1_frames_0", 32'(frames_0), 32'd1);

        // T2: two frames pending on each port from the same cycle
        do_reset();
        push_frame(0, 10, 8'h10, 1);
        push_frame(0, 10, 8'h30, 1);
        push_frame(1, 10, 8'h20, 1);
        push_frame(1, 10, 8'h40, 1);
        for (int i = 0; i < 10; i++) expq.push_back(src0[i]);
        for (int i = 0; i < 10; i++) expq.push_back(src1[i]);
        for (int i = 10; i < 20; i++) expq.push_back(src0[i]);
        for (int i = 10; i < 20; i++) expq.push_back(src1[i]);
        run("t2", 500);
        cmp_stream("t2");
        chk("t2_frames_0", 32'(frames_0), 32'd2);
        chk("t2_frames_1", 32'(frames_1), 32'd2);

        // T3: 60-byte frame on port 1 under a 1,0,0,1 sink-ready pattern
        do_reset();
        mr_toggle = 1;
        push_frame(1, 60, 8'h05, 3);
        expq = src1;
        run("t3", 1000);
        cmp_stream("t3");
        chk("t3_stall_stability_errors", 32'(stall_err), 32'd0);
        chk("t3_frames_1", 32'(frames_1), 32'd1);

        // T5: back-to-back one-byte frames on both ports
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_frame(0, 1, 8'(8'hA0 + i), 1);
            push_frame(1, 1, 8'(8'hB0 + i), 1);
        end
        for (int i = 0; i < 4; i++) begin
            expq.push_back(src0[i]);
            expq.push_back(src1[i]);
        end
        run("t5", 500);
        cmp_stream("t5");
        bad = 0;
        for (int i = 1; i < got_step.size(); i++)
            if (got_step[i] != got_step[i-1] + 1) bad++;
        chk("t5_idle_gaps", 32'(bad), 32'd0);
        chk("t5_frames_0", 32'(frames_0), 32'd4);
        chk("t5_frames_1", 32'(frames_1), 32'd4);

        // T4: 100-byte frame truncated at 64, then a 20-byte frame on port 0
        do_reset();
        hold0 = 1;
        push_frame(1, 100, 8'h00, 1);
        push_frame(0, 20, 8'h80, 1);
        for (int i = 0; i < 64; i++) expq.push_back({8'(i), (i == 63), 1'b1});
        for (int i = 0; i < 20; i++) expq.push_back(src0[i]);
        run("t4", 1000);
        cmp_stream("t4");
        chk("t4_trunc", 32'(trunc_count), 32'd1);
        chk("t4_frames_1", 32'(frames_1), 32'd1);
        chk("t4_frames_0", 32'(frames_0), 32'd1);

        // T6: reset in the middle of a 40-byte frame, counters carried over from T4
        clear_tb();
        push_frame(0, 40, 8'h60, 1);
        n = 0;
        while (in0_step.size() < 15 && n < 200) begin
            step();
            n++;
        end
        chk("t6_reached_byte15", 32'(in0_step.size()), 32'd15);
        @(negedge clk);
        rst = 1;
        s0.tvalid = 0;
        s1.tvalid = 0;
        @(posedge clk);
        #1;
        chk("t6_m_tvalid", 32'(m.tvalid), 32'd0);
        chk("t6_m_tdata", 32'(m.tdata), 32'd0);
        chk("t6_m_tlast", 32'(m.tlast), 32'd0);
        chk("t6_m_src", 32'(m_src), 32'd0);
        chk("t6_frames_0", 32'(frames_0), 32'd0);
        chk("t6_frames_1", 32'(frames_1), 32'd0);
        chk("t6_trunc", 32'(trunc_count), 32'd0);
        @(negedge clk);
        rst = 0;
        clear_tb();
        push_frame(0, 1, 8'h5A, 1);
        push_frame(1, 1, 8'hA5, 1);
        expq.push_back(src0[0]);
        expq.push_back(src1[0]);
        run("t6", 200);
        cmp_stream("t6");
        chk("t6_after_frames_0", 32'(frames_0), 32'd1);
        chk("t6_after_frames_1", 32'(frames_1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
